// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit: op encodings, FSM states,
// iteration count and operand-signedness helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

    // rs1 is treated as signed for everything except MULHU
    function automatic logic op_a_signed(input mul_op_e op);
        return op != OP_MULHU;
    endfunction

    // rs2 is treated as signed only for MUL and MULH
    function automatic logic op_b_signed(input mul_op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/ex_mul_datapath.sv
// Radix-2 shift-add multiplier datapath: magnitude formation at load, one
// add/shift per step into a 64-bit accumulator, sign fix-up on the way out.
module ex_mul_datapath
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [63:0] product
);

    logic [31:0] mcand;
    logic [63:0] acc;
    logic        neg;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] partial;

    // magnitudes are taken before the loop so the loop itself is purely unsigned
    assign a_neg = a_signed & operand_a[31];
    assign b_neg = b_signed & operand_b[31];
    assign a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
    assign b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

    // upper half plus multiplicand when the current multiplier bit is set; carry kept
    assign partial = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);

    // low half starts as the multiplier and is shifted out as the product shifts in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            mcand <= a_mag;
            acc   <= {32'd0, b_mag};
            neg   <= a_neg ^ b_neg;
        end else if (step) begin
            acc   <= {partial, acc[31:1]};
        end
    end

    // final two's-complement negate for a negative product
    assign product = neg ? (~acc + 64'd1) : acc;

endmodule

// File: rtl/ex_mul_unit.sv
// Multi-cycle multiply unit for the EX stage: accepts a request from ID/EX,
// stalls the front of the pipe for 32 iterations plus a sign cycle, then
// pulses done with the selected product word.
module ex_mul_unit
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        reg_write_out
);

    mul_state_e        state;
    mul_op_e           op_q;
    mul_op_e           op_in;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              step;
    logic [63:0]       product;

    assign op_in  = mul_op_e'(op);
    assign accept = (state == ST_IDLE) && start && !flush;
    assign step   = (state == ST_CALC) && !flush;

    assign busy  = (state == ST_CALC) || (state == ST_SIGN);
    // stall asserts in the request cycle itself so ID/EX holds the operands
    assign stall = accept || busy;

    ex_mul_datapath u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      (step),
        .a_signed  (op_a_signed(op_in)),
        .b_signed  (op_b_signed(op_in)),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .product   (product)
    );

    // control FSM; result/rd_out only move in SIGN so a flush leaves them intact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            op_q          <= OP_MUL;
            rd_q          <= '0;
            rw_q          <= 1'b0;
            cnt           <= '0;
            done          <= 1'b0;
            reg_write_out <= 1'b0;
            result        <= '0;
            rd_out        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done          <= 1'b0;
                    reg_write_out <= 1'b0;
                    if (accept) begin
                        op_q  <= op_in;
                        rd_q  <= rd_in;
                        rw_q  <= reg_write_in;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(MUL_ITER - 1))
                            state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result        <= (op_q == OP_MUL) ? product[31:0] : product[63:32];
                        rd_out        <= rd_q;
                        done          <= 1'b1;
                        reg_write_out <= rw_q;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // the completion pulse is already out; flush has nothing to cancel
                    done          <= 1'b0;
                    reg_write_out <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: fixed vectors with hand-computed products,
// latency, stall/busy shape, flush, ignored start and mid-operation reset.
module tb_ex_mul_unit;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  rd_in = '0;
    logic        reg_write_in = 1'b0;
    logic        busy, stall, done, reg_write_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    ex_mul_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flush         (flush),
        .op            (op),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .busy          (busy),
        .stall         (stall),
        .done          (done),
        .result        (result),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out)
    );

    always #5 clk = ~clk;

    // drive a request and let it be taken at the next edge; call at posedge+1
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic w);
        op = o; operand_a = x; operand_b = y; rd_in = r; reg_write_in = w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // count edges until done (-1 on timeout); note whether stall/busy ever dropped early
    task automatic wait_done(output int edges, output logic shape_ok);
        edges = -1;
        shape_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin edges = i; break; end
            if (!stall || !busy) shape_ok = 1'b0;
        end
    endtask

    // count done pulses over a window
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done || reg_write_out) pulses++;
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0 || reg_write_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b/%b exp=0/0", done, reg_write_out); end
        total++; if (result !== 32'h0 || rd_out !== 5'd0) begin bad++; $display("FAIL reset_result got=%h/%0d exp=0/0", result, rd_out); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        // release between edges so the very next edge is the first with reset high
        #9 reset = 1'b1;
    endtask

    task automatic test_mul;
        int e; logic ok;
        op = 2'b00; operand_a = 32'd7; operand_b = 32'hFFFFFFFD; rd_in = 5'd5; reg_write_in = 1'b1;
        start = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall_req got=%b exp=1", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(e, ok);
        total++; if (e !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", e); end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mul_stall_shape got=%b exp=1", ok); end
        total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", result); end
        total++; if (rd_out !== 5'd5 || reg_write_out !== 1'b1) begin bad++; $display("FAIL mul_rd got=%0d/%b exp=5/1", rd_out, reg_write_out); end
        total++; if (stall !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul_done_stall got=%b/%b exp=0/0", stall, busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || reg_write_out !== 1'b0) begin bad++; $display("FAIL mul_pulse_width got=%b/%b exp=0/0", done, reg_write_out); end
        total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_hold got=%h exp=ffffffeb", result); end
    endtask

    task automatic test_mulh_mulhu;
        int e; logic ok;
        issue(2'b01, 32'h80000000, 32'h80000000, 5'd9, 1'b1);
        wait_done(e, ok);
        total++; if (e !== 33 || result !== 32'h40000000) begin bad++; $display("FAIL mulh got=%h lat=%0d exp=40000000 lat=33", result, e); end
        @(posedge clk); #1;
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 1'b1);
        wait_done(e, ok);
        total++; if (e !== 33 || result !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu got=%h lat=%0d exp=fffffffe lat=33", result, e); end
        @(posedge clk); #1;
        // zero operand keeps the fixed latency
        issue(2'b00, 32'h0, 32'h12345678, 5'd11, 1'b1);
        wait_done(e, ok);
        total++; if (e !== 33 || result !== 32'h0) begin bad++; $display("FAIL mul_zero got=%h lat=%0d exp=0 lat=33", result, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_mulhsu_regwrite;
        int e; logic ok;
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 1'b1);
        wait_done(e, ok);
        total++; if (result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu got=%h exp=ffffffff", result); end
        total++; if (reg_write_out !== 1'b1 || rd_out !== 5'd12) begin bad++; $display("FAIL mulhsu_rw got=%b/%0d exp=1/12", reg_write_out, rd_out); end
        @(posedge clk); #1;
        // -3 * 2 = -6, high word all ones; no write requested
        issue(2'b10, 32'hFFFFFFFD, 32'd2, 5'd13, 1'b0);
        wait_done(e, ok);
        total++; if (done !== 1'b1 || reg_write_out !== 1'b0) begin bad++; $display("FAIL norw got=%b/%b exp=1/0", done, reg_write_out); end
        total++; if (result !== 32'hFFFFFFFF || rd_out !== 5'd13) begin bad++; $display("FAIL norw_result got=%h/%0d exp=ffffffff/13", result, rd_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        int e, p; logic ok;
        issue(2'b00, 32'd3, 32'd5, 5'd7, 1'b1);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b/%b exp=0/0", busy, stall); end
        total++; if (result !== 32'hFFFFFFFF || rd_out !== 5'd13) begin bad++; $display("FAIL flush_hold got=%h/%0d exp=ffffffff/13", result, rd_out); end
        count_done(40, p);
        total++; if (p !== 0) begin bad++; $display("FAIL flush_nodone got=%0d exp=0", p); end
        issue(2'b00, 32'd3, 32'd5, 5'd7, 1'b1);
        wait_done(e, ok);
        total++; if (e !== 33 || result !== 32'd15 || rd_out !== 5'd7) begin bad++; $display("FAIL after_flush got=%h/%0d lat=%0d exp=f/7 lat=33", result, rd_out, e); end
        @(posedge clk); #1;
        // flush together with start in IDLE must win
        op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_start_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
        count_done(40, p);
        total++; if (p !== 0 || result !== 32'd15) begin bad++; $display("FAIL flush_start_nodone got=%0d/%h exp=0/f", p, result); end
    endtask

    task automatic test_back_to_back;
        int e; logic ok;
        issue(2'b00, 32'd6, 32'd7, 5'd3, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        op = 2'b11; operand_a = 32'd100; operand_b = 32'd100; rd_in = 5'd30; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done(e, ok);
        total++; if (e !== 25) begin bad++; $display("FAIL busy_start_latency got=%0d exp=25", e); end
        total++; if (result !== 32'd42 || rd_out !== 5'd3) begin bad++; $display("FAIL busy_start_result got=%h/%0d exp=2a/3", result, rd_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int p;
        issue(2'b01, 32'h80000000, 32'h80000000, 5'd21, 1'b1);
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total++; if (result !== 32'h0 || rd_out !== 5'd0) begin bad++; $display("FAIL rst_mid_result got=%h/%0d exp=0/0", result, rd_out); end
        total++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || reg_write_out !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got=%b%b%b%b exp=0000", busy, stall, done, reg_write_out); end
        @(posedge clk); #2;
        reset = 1'b1;
        count_done(40, p);
        total++; if (p !== 0 || result !== 32'h0) begin bad++; $display("FAIL rst_mid_nodone got=%0d/%h exp=0/0", p, result); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mulh_mulhu;
        test_mulhsu_regwrite;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low.
- start  in  1  multiply request, driven by the ID/EX mul-activate flag.
- flush  in  1  abort the request in flight.
- op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand_a  in  32  rs1 value.
- operand_b  in  32  rs2 value.
- rd_in  in  5  destination register.
- reg_write_in  in  1  write enable carried with the request.
- busy  out  1  a multiply is in progress.
- stall  out  1  freeze the IF/ID and ID/EX registers.
- done  out  1  one-cycle completion pulse.
- result  out  32  product word selected by op.
- rd_out  out  5  latched rd_in.
- reg_write_out  out  1  high only while done is high and latched reg_write_in=1.

Function
REQ-003 The FSM SHALL have four states: IDLE, CALC, SIGN, DONE.
REQ-004 In IDLE, start=1 with flush=0 SHALL be accepted at that rising edge.
- Acceptance latches op, operands, rd_in and reg_write_in.
- The 6-bit iteration counter clears to 0.
- Next state: CALC.
REQ-005 Operand magnitudes SHALL be formed at acceptance.
- operand_a is signed for MUL/MULH/MULHSU, unsigned for MULHU.
- operand_b is signed for MUL/MULH, unsigned for MULHSU/MULHU.
- The product sign is the XOR of the operand signs for signed interpretations.
REQ-006 CALC SHALL perform one radix-2 shift-add iteration per cycle into a 64-bit accumulator, for exactly 32 cycles.
REQ-007 After the iteration with counter=31, the state SHALL become SIGN.
REQ-008 SIGN SHALL, in one cycle:
- two's-complement negate the 64-bit accumulator if the product sign is negative;
- register bits [31:0] for MUL, otherwise bits [63:32], into result;
- go to DONE.
REQ-009 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-010 done SHALL go high 33 rising edges after the accepting edge. Latency is fixed and independent of operand values, including zero operands.
REQ-011 busy SHALL be 1 in CALC and SIGN, and 0 in IDLE and DONE.
REQ-012 stall SHALL be combinational and equal (IDLE and start and not flush) or CALC or SIGN. stall SHALL be 0 in DONE so the pipeline advances with the result.
REQ-013 start while busy SHALL be ignored and SHALL NOT corrupt latched operands.
REQ-014 flush in CALC or SIGN SHALL return the FSM to IDLE at the next edge.
- No done or reg_write_out pulse is produced.
- result and rd_out keep their previous values.
REQ-015 If flush and start are both 1 in IDLE, flush SHALL win and the request SHALL NOT be accepted.
REQ-016 flush in DONE SHALL NOT suppress the done pulse already in progress.
REQ-017 result and rd_out SHALL hold their values from SIGN until the next SIGN.

Reset
REQ-018 While reset=0, all of the following SHALL be forced immediately, independent of clk:
- state IDLE; busy 0; done 0; reg_write_out 0;
- result 0x00000000; rd_out 0;
- counter 0; accumulator and latched operands 0.
REQ-019 Assertion of reset mid-operation SHALL discard the operation with no done pulse.
REQ-020 The first start SHALL be accepted at the first rising edge with reset=1.

Structure
REQ-021 A shared package mul_pkg SHALL hold:
- the op encodings;
- the FSM state enumeration;
- the constant MUL_ITER=32.
REQ-022 The shift-add accumulator and the final negate SHALL be a sub-module ex_mul_datapath. FSM, counter and handshake logic SHALL stay in ex_mul_unit.

Verification
REQ-023 MUL, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 edges after acceptance, stall high from the start cycle until DONE.
REQ-024 MULH, a=b=0x80000000 -> 0x40000000; MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-025 MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; reg_write_out pulses with done when reg_write_in=1, and stays 0 when reg_write_in=0.
REQ-026 Flush at CALC counter=10 -> busy=0 and stall=0 next cycle, no done, result unchanged. A following request then completes normally.
REQ-027 start re-asserted with new operands during CALC -> ignored, and the first result is correct. reset pulled low mid-CALC -> all outputs 0 immediately, with no done.
